// File: rtl/seq_mac_bcd_display.sv
// Sequential radix-4 Booth multiply-accumulate with double-dabble BCD conversion
// driving active-low seven-segment displays. Optional macro: SEQ_MAC_DISPLAY_LZB_EN.
module seq_mac_bcd_display #(
  parameter int WIDTH        = 8,
  parameter int ACC_WIDTH    = 2*WIDTH+4,
  parameter int NUM_DISPLAYS = 8,
  parameter int CHECK_PARAM  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start_n,
  input  logic                 acc_mode,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 ready,
  output logic                 overflow,
  output logic [ACC_WIDTH-1:0] result,
  output logic [6:0]           displays [NUM_DISPLAYS]
);
  localparam int E          = ((WIDTH+1) % 2 == 0) ? WIDTH+1 : WIDTH+2;
  localparam int N          = E/2;
  localparam int PW         = 2*E;
  localparam int NUM_DIGITS = ((ACC_WIDTH-1)*30103)/100000 + 1;
  localparam int BW         = 4*NUM_DIGITS;
  localparam int CMAX       = (N > ACC_WIDTH) ? N : ACC_WIDTH;
  localparam int CW         = $clog2(CMAX+1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  if (CHECK_PARAM != 0) begin : g_chk
    if (WIDTH == 0 || ACC_WIDTH < 2*WIDTH+1 || NUM_DISPLAYS < NUM_DIGITS+1) begin : g_bad
      $fatal(1, "seq_mac_bcd_display: illegal parameter combination");
    end
  end

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_ACC, S_CONV, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [E:0]           mplr_q, mplr_d;
  logic [E-1:0]         mcand_q, mcand_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic                 accm_q, accm_d;
  logic                 sgn_q, sgn_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 neg_q, neg_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [6:0]           disp_q [NUM_DISPLAYS];
  logic [6:0]           disp_d [NUM_DISPLAYS];
  logic [6:0]           disp_n [NUM_DISPLAYS];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Operands are widened to E bits so the top Booth group sees the true sign.
  logic [E-1:0] ext_a, ext_b;
  assign ext_a = signed_mode ? {{(E-WIDTH){multiplier[WIDTH-1]}}, multiplier}
                             : {{(E-WIDTH){1'b0}}, multiplier};
  assign ext_b = signed_mode ? {{(E-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                             : {{(E-WIDTH){1'b0}}, multiplicand};

  logic [PW-1:0] mc_ext, pp;
  assign mc_ext = {{(PW-E){mcand_q[E-1]}}, mcand_q};

  always_comb begin
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = mc_ext;
      3'b011:         pp = mc_ext << 1;
      3'b100:         pp = -(mc_ext << 1);
      3'b101, 3'b110: pp = -mc_ext;
      default:        pp = '0;
    endcase
  end

  logic [ACC_WIDTH-1:0] prod_x;
  if (ACC_WIDTH > PW) begin : g_ext
    assign prod_x = {{(ACC_WIDTH-PW){sgn_q & prod_q[PW-1]}}, prod_q};
  end else if (ACC_WIDTH == PW) begin : g_same
    assign prod_x = prod_q;
  end else begin : g_trunc
    assign prod_x = prod_q[ACC_WIDTH-1:0];
  end

  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_nx, mag_nx;
  logic                 ovf_hit, neg_nx;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, prod_x};
    ovf_hit = sgn_q ? ((acc_q[ACC_WIDTH-1] == prod_x[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                    : sum[ACC_WIDTH];
    acc_nx  = accm_q ? sum[ACC_WIDTH-1:0] : prod_x;
    neg_nx  = sgn_q & acc_nx[ACC_WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    mag_nx  = neg_nx ? -acc_nx : acc_nx;
  end

  logic [BW-1:0] bcd_adj;
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    int sign_pos;
`ifdef SEQ_MAC_DISPLAY_LZB_EN
    int msd;
`endif
    for (int i = 0; i < NUM_DISPLAYS; i++) disp_n[i] = SEG_BLANK;
`ifdef SEQ_MAC_DISPLAY_LZB_EN
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) msd = k;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k <= msd) disp_n[k] = seg7(bcd_q[4*k +: 4]);
    end
    sign_pos = msd + 1;
`else
    for (int k = 0; k < NUM_DIGITS; k++) disp_n[k] = seg7(bcd_q[4*k +: 4]);
    sign_pos = NUM_DIGITS;
`endif
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      if (neg_q && i == sign_pos) disp_n[i] = SEG_MINUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state_q <= S_IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!start_n) state_d = S_MULT;
      S_MULT:  if (cnt_q == CW'(N-1)) state_d = S_ACC;
      S_ACC:   state_d = S_CONV;
      S_CONV:  if (cnt_q == CW'(ACC_WIDTH-1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    cnt_d    = cnt_q;
    mplr_d   = mplr_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    accm_d   = accm_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    result_d = result_q;
    disp_d   = disp_q;
    case (state_q)
      S_IDLE: if (!start_n) begin
        mplr_d  = {ext_a, 1'b0};
        mcand_d = ext_b;
        accm_d  = acc_mode;
        sgn_d   = signed_mode;
        prod_d  = '0;
        cnt_d   = '0;
      end
      S_MULT: begin
        prod_d = prod_q + (pp << {cnt_q, 1'b0});
        mplr_d = mplr_q >> 2;
        cnt_d  = cnt_q + CW'(1);
      end
      S_ACC: begin
        acc_d = acc_nx;
        ovf_d = accm_q ? (ovf_q | ovf_hit) : 1'b0;
        bin_d = mag_nx;
        neg_d = neg_nx;
        bcd_d = '0;
        cnt_d = '0;
      end
      S_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: begin
        result_d = acc_q;
        disp_d   = disp_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mplr_q   <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      accm_q   <= 1'b0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
`ifdef SEQ_MAC_DISPLAY_LZB_EN
        disp_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
`else
        disp_q[i] <= (i < NUM_DIGITS) ? SEG_ZERO : SEG_BLANK;
`endif
      end
    end else if (en) begin
      cnt_q    <= cnt_d;
      mplr_q   <= mplr_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      accm_q   <= accm_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      disp_q   <= disp_d;
    end
  end

  assign overflow = ovf_q;
  assign result   = result_q;
  assign displays = disp_q;

endmodule

// File: tb/tb_seq_mac_bcd_display.sv
// Bench for seq_mac_bcd_display at default parameters: vector table plus
// overflow / stall / reset sequences, checked against a scoreboard queue.
module tb_seq_mac_bcd_display;
  localparam int  ND   = 8;
  localparam int  NDIG = 6;
  localparam int  LAT  = 27;
  localparam longint MASK = 64'hFFFFF;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, start_n = 1'b1;
  logic       acc_mode = 1'b0, signed_mode = 1'b0;
  logic [7:0] multiplier = '0, multiplicand = '0;
  logic       ready, overflow;
  logic [19:0] result;
  logic [6:0] displays [ND];

  int total = 0;
  int bad   = 0;
  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  typedef struct { logic [19:0] res; logic ovf; logic [55:0] disp; int lat; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; bit am; bit sm; int stall_at; int stall_len; int pulse_at; } vec_t;
  exp_t sb_q [$];
  vec_t vecs [10];

  seq_mac_bcd_display dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start_n(start_n),
    .acc_mode(acc_mode), .signed_mode(signed_mode),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .ready(ready), .overflow(overflow), .result(result), .displays(displays)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [55:0] disp_model(input longint acc, input bit sm);
    logic [55:0] d;
    longint mag;
    bit neg;
    int dig [NDIG];
    d   = {56{1'b1}};
    neg = sm && (acc >= 524288);
    mag = neg ? (1048576 - acc) : acc;
    for (int i = 0; i < NDIG; i++) begin
      dig[i] = int'(mag % 10);
      mag = mag / 10;
    end
`ifdef SEQ_MAC_DISPLAY_LZB_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < NDIG; i++) if (dig[i] != 0) msd = i;
      for (int i = 0; i <= msd; i++) d[7*i +: 7] = seg_of(dig[i]);
      if (neg) d[7*(msd+1) +: 7] = 7'b0111111;
    end
`else
    for (int i = 0; i < NDIG; i++) d[7*i +: 7] = seg_of(dig[i]);
    if (neg) d[7*NDIG +: 7] = 7'b0111111;
`endif
    return d;
  endfunction

  function automatic logic [55:0] reset_image();
    logic [55:0] d;
    d = {56{1'b1}};
`ifdef SEQ_MAC_DISPLAY_LZB_EN
    d[6:0] = 7'b1000000;
`else
    for (int i = 0; i < NDIG; i++) d[7*i +: 7] = 7'b1000000;
`endif
    return d;
  endfunction

  function automatic logic [55:0] disp_act();
    logic [55:0] d;
    for (int i = 0; i < ND; i++) d[7*i +: 7] = displays[i];
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_push(input vec_t v);
    longint p, s, sa;
    exp_t e;
    if (v.sm) p = longint'($signed(v.a)) * longint'($signed(v.b));
    else      p = longint'(v.a) * longint'(v.b);
    if (!v.am) begin
      m_acc = p & MASK;
      m_ovf = 1'b0;
    end else if (v.sm) begin
      sa = (m_acc >= 524288) ? m_acc - 1048576 : m_acc;
      s  = sa + p;
      if (s > 524287 || s < -524288) m_ovf = 1'b1;
      m_acc = s & MASK;
    end else begin
      s = m_acc + p;
      if (s > MASK) m_ovf = 1'b1;
      m_acc = s & MASK;
    end
    e.res  = 20'(m_acc);
    e.ovf  = m_ovf;
    e.disp = disp_model(m_acc, v.sm);
    e.lat  = LAT + v.stall_len;
    sb_q.push_back(e);
  endtask

  // Called at a negedge with ready high; returns at the negedge where ready is seen high again.
  task automatic do_op(input vec_t v);
    exp_t e;
    int cyc;
    multiplier = v.a; multiplicand = v.b; acc_mode = v.am; signed_mode = v.sm;
    start_n = 1'b0;
    model_push(v);
    @(negedge clk);
    start_n = 1'b1;
    multiplier = ~v.a; multiplicand = ~v.b; acc_mode = ~v.am; signed_mode = ~v.sm;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 200) begin
      cyc++;
      en = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      start_n = (cyc == v.pulse_at) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    en = 1'b1;
    start_n = 1'b1;
    e = sb_q.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("result", 64'(result), 64'(e.res));
    check("overflow", 64'(overflow), 64'(e.ovf));
    check("displays", 64'(disp_act()), 64'(e.disp));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'hF9, 8'h09, 1'b0, 1'b1, -1, 0, -1};   // -7*9
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, -1, 0, -1};   // 65025
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, -1, 0, -1};   // 130050
    vecs[3] = '{8'hF9, 8'h09, 1'b0, 1'b1,  3, 4,  2};   // stall + ignored start
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 1'b1, -1, 0, -1};   // -16256
    vecs[5] = '{8'h80, 8'h7F, 1'b0, 1'b0, -1, 0, -1};   // 16256
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 1'b1, -1, 0, -1};   // back to 0
    vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, -1, 0, -1};   // -1*-1
    vecs[8] = '{8'h00, 8'hFF, 1'b1, 1'b0, -1, 0, -1};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 1'b0, -1, 0, -1};

    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_result", 64'(result), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_displays", 64'(disp_act()), 64'(reset_image()));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i]);
      if (i == 0) check("neg63_value", 64'(result), 64'(20'hFFFC1));
      if (i == 2) check("u_acc_value", 64'(result), 64'(130050));
    end

    // Signed overflow: 32 x 16384 reaches 2^19.
    v = '{8'h80, 8'h80, 1'b0, 1'b1, -1, 0, -1};
    do_op(v);
    v.am = 1'b1;
    for (int k = 0; k < 31; k++) do_op(v);
    check("s_ovf_flag", 64'(overflow), 64'(1));
    check("s_ovf_result", 64'(result), 64'(20'h80000));
    v = '{8'h01, 8'h01, 1'b1, 1'b1, -1, 0, -1};
    do_op(v);
    check("s_ovf_sticky", 64'(overflow), 64'(1));
    v.am = 1'b0;
    do_op(v);
    check("load_clears_ovf", 64'(overflow), 64'(0));
    check("load_one", 64'(result), 64'(1));

    // Unsigned carry-out: 17 x 65025 exceeds 2^20-1.
    v = '{8'hFF, 8'hFF, 1'b0, 1'b0, -1, 0, -1};
    do_op(v);
    v.am = 1'b1;
    for (int k = 0; k < 16; k++) do_op(v);
    check("u_ovf_flag", 64'(overflow), 64'(1));

    // Asynchronous reset in the middle of BCD conversion.
    multiplier = 8'h05; multiplicand = 8'h03; acc_mode = 1'b1; signed_mode = 1'b1;
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midconv_busy", 64'(ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("midconv_rst_ready", 64'(ready), 64'(1));
    check("midconv_rst_result", 64'(result), 64'(0));
    check("midconv_rst_ovf", 64'(overflow), 64'(0));
    check("midconv_rst_disp", 64'(disp_act()), 64'(reset_image()));
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    v = '{8'h02, 8'h03, 1'b1, 1'b1, -1, 0, -1};
    do_op(v);
    check("acc_after_reset", 64'(result), 64'(6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
